// File: rtl/threshold_persist_detector.sv
`default_nettype none
// ============================================================================
// Module   : threshold_persist_detector
// Brief    : "At least K of N" detector. Counts asserted input channels,
//            compares the count against a runtime threshold, debounces the
//            result with a programmable persistence filter, and emits a
//            one-cycle rise pulse plus a saturating event counter.
// Revision : 1.0 - initial release
// ============================================================================
module threshold_persist_detector #(
    parameter  int NBITS = 8,
    parameter  int HW    = 4,
    parameter  int EW    = 8,
    localparam int PW    = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NBITS-1:0] in,
    input  logic [PW-1:0]    thresh,
    input  logic [HW-1:0]    hold,
    input  logic             clr,
    output logic [PW-1:0]    count,
    output logic             det,
    output logic             out,
    output logic             rise,
    output logic [EW-1:0]    events
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_arming = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;

    logic [PW-1:0] w_pop;
    logic          w_cmp;
    logic [PW-1:0] r_count;
    logic          r_det;
    logic          r_v1;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [HW-1:0] r_run;
    logic [HW-1:0] w_run_nxt;
    logic          r_rise;
    logic          w_rise_nxt;
    logic          r_out;
    logic [EW-1:0] r_events;

    logic [HW-1:0] w_hold_eff;
    logic [HW:0]   w_run_inc;
    logic [HW-1:0] w_run_sat;

    // Population count of the channel inputs and the unsigned threshold compare.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_pop = w_pop + PW'(in[i]);
        end
        w_cmp = (w_pop >= thresh);
    end

    // Stage 1: capture count/compare on enabled samples; v1 marks a fresh sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_det   <= 1'b0;
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= en;
            if (en) begin
                r_count <= w_pop;
                r_det   <= w_cmp;
            end
        end
    end

    // A hold of zero means "one sample is enough"; the run increment is kept
    // one bit wider so the compare against the hold cannot wrap.
    assign w_hold_eff = (hold == '0) ? HW'(1) : hold;
    assign w_run_inc  = (HW + 1)'(r_run) + (HW + 1)'(1);
    assign w_run_sat  = (r_run == '1) ? r_run : r_run + HW'(1);

    // Stage 2 next-state: only advances on a fresh sample, otherwise frozen.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_rise_nxt  = 1'b0;
        if (r_v1) begin
            case (r_state)
                c_st_idle: begin
                    if (r_det) begin
                        if (w_hold_eff == HW'(1)) begin
                            w_state_nxt = c_st_active;
                            w_rise_nxt  = 1'b1;
                        end else begin
                            w_run_nxt   = HW'(1);
                            w_state_nxt = c_st_arming;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                c_st_arming: begin
                    if (!r_det) begin
                        w_state_nxt = c_st_idle;
                        w_run_nxt   = '0;
                    end else if (w_run_inc >= {1'b0, w_hold_eff}) begin
                        w_state_nxt = c_st_active;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_run_nxt = w_run_sat;
                    end
                end
                c_st_active: begin
                    if (!r_det) begin
                        w_state_nxt = c_st_idle;
                        w_run_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // Stage 2 state register with registered out/rise decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_run   <= '0;
            r_rise  <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_rise  <= w_rise_nxt;
            r_out   <= (w_state_nxt == c_st_active);
        end
    end

    // Saturating count of rise pulses; clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_events <= '0;
        end else if (clr) begin
            r_events <= '0;
        end else if (w_rise_nxt && (r_events != '1)) begin
            r_events <= r_events + EW'(1);
        end
    end

    assign count  = r_count;
    assign det    = r_det;
    assign out    = r_out;
    assign rise   = r_rise;
    assign events = r_events;

endmodule
`default_nettype wire

// File: tb/tb_threshold_persist_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_threshold_persist_detector
// Brief    : Randomised and directed bench for threshold_persist_detector
//            against a streak-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_threshold_persist_detector;

    localparam int NBITS = 8;
    localparam int HW    = 4;
    localparam int EW    = 8;
    localparam int PW    = $clog2(NBITS + 1);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [NBITS-1:0] in;
    logic [PW-1:0]    thresh;
    logic [HW-1:0]    hold;
    logic             clr;
    logic [PW-1:0]    count;
    logic             det;
    logic             out;
    logic             rise;
    logic [EW-1:0]    events;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: a detect streak length instead of an FSM.
    int m_count;
    int m_streak;
    int m_events;
    bit m_det;
    bit m_v1;
    bit m_out;
    bit m_rise;

    threshold_persist_detector #(.NBITS(NBITS), .HW(HW), .EW(EW)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in),
        .thresh (thresh),
        .hold   (hold),
        .clr    (clr),
        .count  (count),
        .det    (det),
        .out    (out),
        .rise   (rise),
        .events (events)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_det    = 0;
        m_v1     = 0;
        m_streak = 0;
        m_out    = 0;
        m_rise   = 0;
        m_events = 0;
    endtask

    // One clock edge of the model: an output is active once the streak of
    // consecutive detecting samples reaches max(hold,1).
    task automatic model_edge();
        int h;
        int pop;
        bit new_rise;
        h = (hold == 0) ? 1 : int'(hold);
        new_rise = 0;
        if (m_v1) begin
            if (!m_det) begin
                m_out    = 0;
                m_streak = 0;
            end else if (!m_out) begin
                m_streak++;
                if (m_streak >= h) begin
                    m_out    = 1;
                    new_rise = 1;
                end
            end
        end
        m_rise = new_rise;
        if (clr) m_events = 0;
        else if (new_rise && m_events < 255) m_events++;
        if (en) begin
            pop     = $countones(in);
            m_count = pop;
            m_det   = (pop >= int'(thresh));
        end
        m_v1 = en;
    endtask

    task automatic check_all();
        check("count",  32'(count),  32'(m_count));
        check("det",    32'(det),    32'(m_det));
        check("out",    32'(out),    32'(m_out));
        check("rise",   32'(rise),   32'(m_rise));
        check("events", 32'(events), 32'(m_events));
    endtask

    // Drive inputs away from the edge, clock once, update model, compare.
    task automatic step(input logic e, input logic [NBITS-1:0] i, input logic [PW-1:0] t,
                        input logic [HW-1:0] h, input logic c);
        en = e; in = i; thresh = t; hold = h; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in = '0; thresh = '0; hold = '0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Pair/triple function on the low three channels.
        for (int v = 0; v < 8; v++) begin
            step(1'b1, 8'(v), 4'd2, 4'd1, 1'b0);
            check("pair_det", 32'(det), 32'((v == 3 || v == 5 || v == 6 || v == 7) ? 1 : 0));
        end
        step(1'b1, 8'h00, 4'd2, 4'd1, 1'b0);
        step(1'b1, 8'h00, 4'd2, 4'd1, 1'b0);
        step(1'b1, 8'h03, 4'd2, 4'd1, 1'b0);
        check("pair_det1", 32'(det), 32'd1);
        step(1'b1, 8'h03, 4'd2, 4'd1, 1'b0);
        check("pair_out", 32'(out), 32'd1);
        check("pair_rise", 32'(rise), 32'd1);
        step(1'b1, 8'h03, 4'd2, 4'd1, 1'b0);
        check("pair_rise_end", 32'(rise), 32'd0);

        // Persistence: popcounts 5,5,3,5,5,5 with hold=3.
        step(1'b1, 8'h00, 4'd4, 4'd3, 1'b1);
        step(1'b0, 8'h00, 4'd4, 4'd3, 1'b0);
        step(1'b1, 8'h1F, 4'd4, 4'd3, 1'b0);
        step(1'b1, 8'h1F, 4'd4, 4'd3, 1'b0);
        step(1'b1, 8'h07, 4'd4, 4'd3, 1'b0);
        step(1'b1, 8'h1F, 4'd4, 4'd3, 1'b0);
        step(1'b1, 8'h1F, 4'd4, 4'd3, 1'b0);
        step(1'b1, 8'h1F, 4'd4, 4'd3, 1'b0);
        check("persist_out_early", 32'(out), 32'd0);
        step(1'b0, 8'h00, 4'd4, 4'd3, 1'b0);
        check("persist_out", 32'(out), 32'd1);
        check("persist_events", 32'(events), 32'd1);

        // Enable gaps: count/det hold while en=0.
        step(1'b1, 8'h00, 4'd1, 4'd2, 1'b0);
        step(1'b0, 8'h00, 4'd1, 4'd2, 1'b0);
        step(1'b1, 8'h01, 4'd1, 4'd2, 1'b0);
        step(1'b0, 8'hFF, 4'd1, 4'd2, 1'b0);
        check("gap_count", 32'(count), 32'd1);
        step(1'b0, 8'hFF, 4'd1, 4'd2, 1'b0);
        step(1'b1, 8'h01, 4'd1, 4'd2, 1'b0);
        check("gap_out_early", 32'(out), 32'd0);
        step(1'b0, 8'h00, 4'd1, 4'd2, 1'b0);
        check("gap_out", 32'(out), 32'd1);

        // Threshold boundaries.
        step(1'b1, 8'h00, 4'd0, 4'd1, 1'b0);
        check("th0_det", 32'(det), 32'd1);
        check("th0_count", 32'(count), 32'd0);
        step(1'b1, 8'hFF, 4'd9, 4'd1, 1'b0);
        step(1'b1, 8'hFF, 4'd9, 4'd1, 1'b0);
        step(1'b1, 8'hFF, 4'd9, 4'd1, 1'b0);
        check("th9_det", 32'(det), 32'd0);
        check("th9_count", 32'(count), 32'd8);
        check("th9_out", 32'(out), 32'd0);
        // hold=0 fires after a single detecting sample.
        step(1'b1, 8'h01, 4'd1, 4'd0, 1'b0);
        step(1'b1, 8'h01, 4'd1, 4'd0, 1'b0);
        check("hold0_out", 32'(out), 32'd1);

        // 260 rise pulses saturate the event counter.
        step(1'b1, 8'h00, 4'd1, 4'd1, 1'b1);
        step(1'b1, 8'h00, 4'd1, 4'd1, 1'b0);
        for (int k = 0; k < 260; k++) begin
            step(1'b1, 8'h01, 4'd1, 4'd1, 1'b0);
            step(1'b1, 8'h00, 4'd1, 4'd1, 1'b0);
        end
        step(1'b1, 8'h00, 4'd1, 4'd1, 1'b0);
        check("events_sat", 32'(events), 32'd255);
        // clr coincident with a rise.
        step(1'b1, 8'h01, 4'd1, 4'd1, 1'b0);
        step(1'b1, 8'h01, 4'd1, 4'd1, 1'b1);
        check("clr_rise", 32'(rise), 32'd1);
        check("clr_events", 32'(events), 32'd0);
        check("clr_out", 32'(out), 32'd1);

        // Async reset mid-ACTIVE, between edges.
        step(1'b1, 8'hFF, 4'd1, 4'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h01, 4'd1, 4'd1, 1'b0);
        step(1'b0, 8'h00, 4'd1, 4'd1, 1'b0);
        check("post_rst_out", 32'(out), 32'd1);

        // Randomised traffic with occasional hold changes and clears.
        begin
            logic [HW-1:0] h_r;
            logic [PW-1:0] t_r;
            h_r = 4'd2;
            t_r = 4'd3;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 19) == 0) h_r = 4'($urandom_range(0, 5));
                if ($urandom_range(0, 29) == 0) t_r = 4'($urandom_range(0, 10));
                step(($urandom_range(0, 3) != 0), 8'($urandom), t_r, h_r,
                     ($urandom_range(0, 49) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global timeout so the bench always terminates.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout got=0 exp=1");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
